// File: rtl/seg_pkg.sv
// Shared 7-segment pattern table (active-high {A..G}) and decode result type.
// Used by both the cathode encoder and the scan read-back decoder.
package seg_pkg;

   localparam logic [6:0] SEG_PAT_0     = 7'b1111110;
   localparam logic [6:0] SEG_PAT_1     = 7'b0110000;
   localparam logic [6:0] SEG_PAT_2     = 7'b1101101;
   localparam logic [6:0] SEG_PAT_3     = 7'b1111001;
   localparam logic [6:0] SEG_PAT_4     = 7'b0110011;
   localparam logic [6:0] SEG_PAT_5     = 7'b1011011;
   localparam logic [6:0] SEG_PAT_6     = 7'b1011111;
   localparam logic [6:0] SEG_PAT_7     = 7'b1110000;
   localparam logic [6:0] SEG_PAT_8     = 7'b1111111;
   localparam logic [6:0] SEG_PAT_9     = 7'b1111011;
   localparam logic [6:0] SEG_PAT_BLANK = 7'b0000000;

   localparam logic [3:0] DIGIT_BLANK   = 4'hF;

   typedef struct packed {
      logic       legal;
      logic [3:0] value;
   } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to digit value; 0 cycles latency, no flow control.
// Unknown patterns return legal=0 with value DIGIT_BLANK.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] i_pattern,
   output seg_dec_t   o_dec
);

   always_comb begin
      o_dec = '{legal: 1'b1, value: 4'h0};
      case (i_pattern)
         SEG_PAT_0:     o_dec.value = 4'd0;
         SEG_PAT_1:     o_dec.value = 4'd1;
         SEG_PAT_2:     o_dec.value = 4'd2;
         SEG_PAT_3:     o_dec.value = 4'd3;
         SEG_PAT_4:     o_dec.value = 4'd4;
         SEG_PAT_5:     o_dec.value = 4'd5;
         SEG_PAT_6:     o_dec.value = 4'd6;
         SEG_PAT_7:     o_dec.value = 4'd7;
         SEG_PAT_8:     o_dec.value = 4'd8;
         SEG_PAT_9:     o_dec.value = 4'd9;
         SEG_PAT_BLANK: o_dec.value = DIGIT_BLANK;
         default:       o_dec = '{legal: 1'b0, value: DIGIT_BLANK};
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-position digits from a scanned active-low 7-seg bus (sync, debounce, decode).
// Latency 2 + STABLE_CYCLES + 1 clk from a held bus change; passive receiver, no backpressure.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8,
   parameter int CNT_W         = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   input  logic [6:0]              seg_n,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    invalid_pulse,
   output logic                    frame_done
);

   localparam int SW = NUM_DIGITS + 7;

   logic [SW-1:0]           r_sync1;
   logic [SW-1:0]           r_samp;
   logic [SW-1:0]           r_prev;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_committed;
   logic [NUM_DIGITS-1:0]   r_mask;
   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [NUM_DIGITS-1:0]   r_valid;
   logic                    r_invalid;
   logic                    r_frame;

   logic                    w_stable;
   logic                    w_capture;
   logic [NUM_DIGITS-1:0]   w_an_act;
   logic                    w_onehot;
   logic                    w_cap_hit;
   logic                    w_frame_full;
   logic [NUM_DIGITS-1:0]   w_mask_next;
   seg_dec_t                w_dec;

   seg_pattern_decode u_decode (
      .i_pattern (~r_samp[6:0]),
      .o_dec     (w_dec)
   );

   assign w_stable     = (r_samp == r_prev);
   assign w_capture    = w_stable && !r_committed && (r_cnt == CNT_W'(STABLE_CYCLES - 1));
   assign w_an_act     = ~r_samp[SW-1:7];
   assign w_onehot     = (w_an_act != '0) && ((w_an_act & (w_an_act - NUM_DIGITS'(1))) == '0);
   assign w_cap_hit    = w_capture && w_onehot;
   assign w_frame_full = &r_mask;
   // A capture landing in the frame_done cycle seeds the fresh mask instead of being dropped.
   assign w_mask_next  = (w_frame_full ? '0 : r_mask) | (w_cap_hit ? w_an_act : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1     <= '1;
         r_samp      <= '1;
         r_prev      <= '1;
         r_cnt       <= '0;
         r_committed <= 1'b0;
         r_mask      <= '0;
         r_digits    <= {NUM_DIGITS{DIGIT_BLANK}};
         r_valid     <= '0;
         r_invalid   <= 1'b0;
         r_frame     <= 1'b0;
      end else begin
         r_sync1 <= {an_n, seg_n};
         r_samp  <= r_sync1;
         r_prev  <= r_samp;

         if (!w_stable) begin
            r_cnt       <= '0;
            r_committed <= 1'b0;
         end else begin
            if (r_cnt != CNT_W'(STABLE_CYCLES - 1)) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
               r_committed <= 1'b1;
            end
         end

         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_cap_hit && w_an_act[i]) begin
               if (w_dec.legal) begin
                  r_digits[4*i +: 4] <= w_dec.value;
               end
               r_valid[i] <= w_dec.legal;
            end
         end

         r_invalid <= w_cap_hit && !w_dec.legal;
         r_frame   <= w_frame_full;
         r_mask    <= w_mask_next;
      end
   end

   assign digits_out    = r_digits;
   assign digit_valid   = r_valid;
   assign invalid_pulse = r_invalid;
   assign frame_done    = r_frame;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and random scan bus holds checked against a transaction-level display model.
module tb_seg_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [ND-1:0] an_n;
   logic [6:0]    seg_n;
   logic [15:0]   digits_out;
   logic [ND-1:0] digit_valid;
   logic          invalid_pulse;
   logic          frame_done;

   seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .an_n          (an_n),
      .seg_n         (seg_n),
      .digits_out    (digits_out),
      .digit_valid   (digit_valid),
      .invalid_pulse (invalid_pulse),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [0:10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                              7'b0000000};

   int n_chk = 0;
   int n_fail = 0;
   int n_inv = 0;
   int n_frame = 0;

   logic [3:0] m_dig [0:3];
   logic [3:0] m_valid;
   logic [3:0] m_mask;
   int         m_inv = 0;
   int         m_frames = 0;
   logic [10:0] last_bus;

   always @(negedge clk) begin
      if (invalid_pulse === 1'b1) n_inv++;
      if (frame_done === 1'b1) n_frame++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i <= 10; i++) begin
         if (tbl[i] == p) return (i == 10) ? 15 : i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] exp_digits();
      return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
      m_valid  = '0;
      m_mask   = '0;
      last_bus = '1;
   endtask

   // A display position shows one digit: capture updates that position and frame bookkeeping.
   task automatic model_cap(input logic [3:0] an, input logic [6:0] seg);
      logic [3:0] act;
      int idx;
      int v;
      act = ~an;
      if ($countones(act) != 1) return;
      idx = 0;
      for (int i = 0; i < 4; i++) if (act[i]) idx = i;
      v = decode(~seg);
      if (v >= 0) begin
         m_dig[idx]   = 4'(v);
         m_valid[idx] = 1'b1;
      end else begin
         m_valid[idx] = 1'b0;
         m_inv++;
      end
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
         m_frames++;
         m_mask = '0;
      end
   endtask

   // Holds of n >= SC+1 cycles are captured; lengths used are <= 6 or >= 14 so results settle in-hold.
   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n, input string tag);
      an_n  = an;
      seg_n = seg;
      repeat (n) @(posedge clk);
      #1;
      if (n >= SC + 1) model_cap(an, seg);
      last_bus = {an, seg};
      check({tag, " digits"}, 32'(digits_out), 32'(exp_digits()));
      check({tag, " valid"}, 32'(digit_valid), 32'(m_valid));
      check({tag, " invalid count"}, n_inv, m_inv);
      check({tag, " frame count"}, n_frame, m_frames);
   endtask

   task automatic gen(output logic [3:0] an, output logic [6:0] seg);
      int kind;
      int pos;
      logic [3:0] one;
      logic [6:0] p;
      kind = $urandom_range(0, 9);
      pos  = $urandom_range(0, 3);
      one  = 4'b0001;
      an   = ~(one << pos);
      if (kind < 7) begin
         seg = ~tbl[$urandom_range(0, 10)];
      end else if (kind < 9) begin
         p = 7'($urandom);
         while (decode(p) != -1) p = 7'($urandom);
         seg = ~p;
      end else begin
         an = 4'($urandom);
         while ($countones(~an) == 1) an = 4'($urandom);
         seg = 7'($urandom);
      end
   endtask

   initial begin
      logic [3:0] ran;
      logic [6:0] rseg;
      int len;

      model_reset();

      // 1: reset with a random bus
      rst_n = 1'b0;
      an_n  = 4'($urandom);
      seg_n = 7'($urandom);
      repeat (4) @(posedge clk);
      #1;
      check("reset digits", 32'(digits_out), 32'hFFFF);
      check("reset valid", 32'(digit_valid), 32'h0);
      check("reset invalid_pulse", 32'(invalid_pulse), 32'h0);
      check("reset frame_done", 32'(frame_done), 32'h0);
      check("reset pulse counts", n_inv + n_frame, 0);

      // 2: single capture latency
      an_n  = 4'b1110;
      seg_n = ~7'b1101101;
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (e == 10) begin
            check("lat edge10 digits", 32'(digits_out), 32'hFFFF);
            check("lat edge10 valid", 32'(digit_valid), 32'h0);
         end
         if (e == 11) begin
            check("lat edge11 digits", 32'(digits_out), 32'hFFF2);
            check("lat edge11 valid", 32'(digit_valid), 32'h1);
         end
      end
      model_cap(4'b1110, ~7'b1101101);
      last_bus = {4'b1110, ~7'b1101101};
      check("single capture pulses", n_inv + n_frame, 0);

      // 3: scan 3,1,4,7
      hold(4'b1110, ~tbl[3], 16, "scan p0");
      hold(4'b1101, ~tbl[1], 16, "scan p1");
      hold(4'b1011, ~tbl[4], 16, "scan p2");
      hold(4'b0111, ~tbl[7], 16, "scan p3");
      check("scan digits", 32'(digits_out), 32'h7413);
      check("scan valid", 32'(digit_valid), 32'hF);
      check("scan frame_done", n_frame, 1);

      // 4: illegal pattern keeps the slot but clears valid
      hold(4'b1110, ~tbl[2], 16, "pre-illegal");
      hold(4'b1110, ~7'b1000001, 16, "illegal");
      check("illegal slot0", 32'(digits_out[3:0]), 32'h2);
      check("illegal valid0", 32'(digit_valid[0]), 32'h0);
      check("illegal pulses", n_inv, 1);

      // 5: short runs, glitch, multi-anode, blank
      hold(4'b1101, ~tbl[5], 5, "short run");
      hold(4'b1011, ~tbl[8], 1, "glitch");
      hold(4'b1100, ~tbl[3], 16, "two anodes");
      hold(4'b1101, 7'h7F, 16, "blank");
      check("blank slot1", 32'(digits_out[7:4]), 32'hF);
      check("blank valid1", 32'(digit_valid[1]), 32'h1);

      // 6: reset mid-frame
      hold(4'b1110, ~tbl[6], 16, "mid p0");
      hold(4'b1101, ~tbl[9], 16, "mid p1");
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midreset digits", 32'(digits_out), 32'hFFFF);
      check("midreset valid", 32'(digit_valid), 32'h0);
      an_n  = 4'hF;
      seg_n = 7'h7F;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(4'b1110, ~tbl[0], 16, "post p0");
      hold(4'b1101, ~tbl[1], 16, "post p1");
      hold(4'b1011, ~tbl[2], 16, "post p2");
      check("post no early frame", n_frame, m_frames);
      hold(4'b0111, ~tbl[3], 16, "post p3");
      check("post frame", 32'(digits_out), 32'h3210);

      // random holds
      for (int k = 0; k < 60; k++) begin
         gen(ran, rseg);
         while ({ran, rseg} == last_bus) gen(ran, rseg);
         len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(14, 20);
         hold(ran, rseg, len, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
